// File: rtl/fifo_frame_pkg.sv
// Shared constants and state encoding for the write-domain SLIP framer.
package fifo_frame_pkg;
  localparam int DSIZE = 8;
  localparam logic [7:0] FLAG_DEF = 8'hC0;
  localparam logic [7:0] ESC_DEF  = 8'hDB;
  localparam logic [7:0] XOR_DEF  = 8'h20;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_ESC, S_EOF} state_t;

  function automatic logic needs_esc(input logic [7:0] b, input logic [7:0] flag,
                                     input logic [7:0] esc);
    return (b == flag) || (b == esc);
  endfunction
endpackage

// File: rtl/fifo_wr_slip_framer.sv
// SLIP-style framer driving the write port of a dual-clock FIFO: escapes FLAG/ESC
// bytes and delimits each packet with FLAG, writing only while the FIFO is not full.
module fifo_wr_slip_framer #(
  parameter int               DSIZE    = fifo_frame_pkg::DSIZE,
  parameter logic [DSIZE-1:0] FLAG     = fifo_frame_pkg::FLAG_DEF,
  parameter logic [DSIZE-1:0] ESC      = fifo_frame_pkg::ESC_DEF,
  parameter logic [DSIZE-1:0] XOR_MASK = fifo_frame_pkg::XOR_DEF,
  parameter bit               SOF_EN   = 1'b1,
  parameter int               CNT_W    = 16
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [DSIZE-1:0] s_data,
  input  logic             s_last,
  output logic [DSIZE-1:0] wdata,
  output logic             winc,
  input  logic             wfull,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] esc_cnt
);
  import fifo_frame_pkg::*;

  state_t           state, nxt;
  logic [DSIZE-1:0] esc_byte;
  logic             esc_last;
  logic             emit_valid;
  logic [DSIZE-1:0] emit_byte;
  logic             fire;
  logic             latch_esc;
  logic             close_frame;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state     <= S_IDLE;
      esc_byte  <= '0;
      esc_last  <= 1'b0;
      frame_cnt <= '0;
      esc_cnt   <= '0;
    end else begin
      state <= nxt;
      if (latch_esc) begin
        esc_byte <= s_data ^ XOR_MASK;
        esc_last <= s_last;
        esc_cnt  <= esc_cnt + CNT_W'(1);
      end
      if (close_frame) frame_cnt <= frame_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    emit_valid  = 1'b0;
    emit_byte   = FLAG;
    nxt         = state;
    latch_esc   = 1'b0;
    close_frame = 1'b0;

    case (state)
      S_IDLE:  if (s_valid && SOF_EN) emit_valid = 1'b1;
      S_DATA: begin
        if (s_valid) begin
          emit_valid = 1'b1;
          emit_byte  = needs_esc(s_data, FLAG, ESC) ? ESC : s_data;
        end
      end
      S_ESC: begin
        emit_valid = 1'b1;
        emit_byte  = esc_byte;
      end
      S_EOF:   emit_valid = 1'b1;
      default: ;
    endcase

    // Writes are suppressed while reset is held so the FIFO never sees a stray strobe.
    fire = emit_valid & ~wfull & wrst_n;

    case (state)
      S_IDLE: begin
        if (s_valid && (fire || !SOF_EN)) nxt = S_DATA;
      end
      S_DATA: begin
        if (fire) begin
          if (needs_esc(s_data, FLAG, ESC)) begin
            latch_esc = 1'b1;
            nxt       = S_ESC;
          end else if (s_last) begin
            nxt = S_EOF;
          end
        end
      end
      S_ESC:   if (fire) nxt = esc_last ? S_EOF : S_DATA;
      S_EOF: begin
        if (fire) begin
          close_frame = 1'b1;
          nxt         = S_IDLE;
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  assign winc    = fire;
  assign wdata   = fire ? emit_byte : '0;
  assign s_ready = (state == S_DATA) & ~wfull;
  assign busy    = (state != S_IDLE);

endmodule

// File: tb/tb_fifo_wr_slip_framer.sv
// Directed bench: instance A (SOF_EN=1, 16-bit counters), instance B (SOF_EN=0, 4-bit counters).
module tb_fifo_wr_slip_framer;
  typedef logic [7:0] bq_t[$];

  logic wclk = 1'b0;
  logic wrst_n = 1'b0;
  always #5 wclk = ~wclk;

  logic        a_valid = 1'b0, a_last = 1'b0, a_wfull = 1'b0;
  logic [7:0]  a_data = '0;
  logic        a_ready, a_winc, a_busy;
  logic [7:0]  a_wdata;
  logic [15:0] a_frame_cnt, a_esc_cnt;

  logic        b_valid = 1'b0, b_last = 1'b0, b_wfull = 1'b0;
  logic [7:0]  b_data = '0;
  logic        b_ready, b_winc, b_busy;
  logic [7:0]  b_wdata;
  logic [3:0]  b_frame_cnt, b_esc_cnt;

  fifo_wr_slip_framer #(.SOF_EN(1'b1), .CNT_W(16)) dut_a (
    .wclk(wclk), .wrst_n(wrst_n), .s_valid(a_valid), .s_ready(a_ready),
    .s_data(a_data), .s_last(a_last), .wdata(a_wdata), .winc(a_winc),
    .wfull(a_wfull), .busy(a_busy), .frame_cnt(a_frame_cnt), .esc_cnt(a_esc_cnt));

  fifo_wr_slip_framer #(.SOF_EN(1'b0), .CNT_W(4)) dut_b (
    .wclk(wclk), .wrst_n(wrst_n), .s_valid(b_valid), .s_ready(b_ready),
    .s_data(b_data), .s_last(b_last), .wdata(b_wdata), .winc(b_winc),
    .wfull(b_wfull), .busy(b_busy), .frame_cnt(b_frame_cnt), .esc_cnt(b_esc_cnt));

  int nchk = 0;
  int nerr = 0;
  bq_t qa, qb;
  logic [15:0] ea_frm = '0, ea_esc = '0;
  logic [3:0]  eb_frm = '0, eb_esc = '0;

  function automatic bq_t frame_of(input bq_t p, input bit sof);
    bq_t r;
    r = {};
    if (sof) r.push_back(8'hC0);
    foreach (p[i]) begin
      if (p[i] == 8'hC0 || p[i] == 8'hDB) begin
        r.push_back(8'hDB);
        r.push_back(p[i] ^ 8'h20);
      end else begin
        r.push_back(p[i]);
      end
    end
    r.push_back(8'hC0);
    return r;
  endfunction

  // Scoreboards: every FIFO write must match the next expected byte.
  always @(negedge wclk) begin
    nchk++;
    if (a_winc) begin
      assert (qa.size() != 0) else begin
        nerr++; $error("FAIL a_unexpected_write: got %02h required none", a_wdata);
      end
      if (qa.size() != 0) begin
        logic [7:0] e;
        e = qa.pop_front();
        assert (a_wdata === e) else begin
          nerr++; $error("FAIL a_wdata: got %02h required %02h", a_wdata, e);
        end
      end
    end else begin
      assert (a_wdata === 8'h00) else begin
        nerr++; $error("FAIL a_wdata_idle: got %02h required 00", a_wdata);
      end
    end
  end

  always @(negedge wclk) begin
    nchk++;
    if (b_winc) begin
      assert (qb.size() != 0) else begin
        nerr++; $error("FAIL b_unexpected_write: got %02h required none", b_wdata);
      end
      if (qb.size() != 0) begin
        logic [7:0] e;
        e = qb.pop_front();
        assert (b_wdata === e) else begin
          nerr++; $error("FAIL b_wdata: got %02h required %02h", b_wdata, e);
        end
      end
    end else begin
      assert (b_wdata === 8'h00) else begin
        nerr++; $error("FAIL b_wdata_idle: got %02h required 00", b_wdata);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++; $error("FAIL %s: got %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_pkt(input bit b, input bq_t p);
    bq_t f;
    f = frame_of(p, !b);
    foreach (f[i]) begin
      if (b) qb.push_back(f[i]); else qa.push_back(f[i]);
    end
    foreach (p[i]) begin
      if (p[i] == 8'hC0 || p[i] == 8'hDB) begin
        if (b) eb_esc++; else ea_esc++;
      end
    end
    if (b) eb_frm++; else ea_frm++;
  endtask

  task automatic put(input bit b, input logic [7:0] d, input logic l);
    bit ok;
    ok = 1'b0;
    if (b) begin b_valid = 1'b1; b_data = d; b_last = l; end
    else   begin a_valid = 1'b1; a_data = d; a_last = l; end
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge wclk);
      if (b ? b_ready : a_ready) begin
        @(posedge wclk);
        #1;
        ok = 1'b1;
      end
    end
    nchk++;
    assert (ok) else begin
      nerr++; $error("FAIL handshake_timeout: got no accept required accept of %02h", d);
    end
  endtask

  task automatic send(input bit b, input bq_t p, input bit hold);
    expect_pkt(b, p);
    foreach (p[i]) put(b, p[i], (i == p.size() - 1));
    if (!hold) begin
      if (b) b_valid = 1'b0; else a_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input bit b);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge wclk);
      if (b ? (!b_busy && qb.size() == 0) : (!a_busy && qa.size() == 0)) ok = 1'b1;
    end
    nchk++;
    assert (ok) else begin
      nerr++; $error("FAIL idle_timeout: got busy/pending required idle (inst %0d)", b);
    end
  endtask

  initial begin
    bq_t pkt;

    // Reset state
    @(negedge wclk);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_a_winc",  a_winc, 0);
    chk("rst_a_busy",  a_busy, 0);
    chk("rst_a_frame", a_frame_cnt, 0);
    chk("rst_a_esc",   a_esc_cnt, 0);
    wrst_n = 1'b1;
    @(negedge wclk);

    // 1: plain packet
    pkt = {8'h01, 8'h02, 8'h03};
    send(0, pkt, 0);
    wait_idle(0);
    chk("t1_frame", a_frame_cnt, ea_frm);
    chk("t1_esc",   a_esc_cnt, ea_esc);

    // 2: escaped bytes
    pkt = {8'hC0, 8'hDB, 8'h55};
    send(0, pkt, 0);
    wait_idle(0);
    chk("t2_frame", a_frame_cnt, ea_frm);
    chk("t2_esc",   a_esc_cnt, ea_esc);

    // 3: backpressure while in S_ESC holding E0
    pkt = {8'hC0, 8'h33};
    expect_pkt(0, pkt);
    put(0, 8'hC0, 1'b0);
    a_data = 8'h33; a_last = 1'b1;
    a_wfull = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge wclk);
      chk("t3_winc",  a_winc, 0);
      chk("t3_ready", a_ready, 0);
      chk("t3_busy",  a_busy, 1);
    end
    a_wfull = 1'b0;
    put(0, 8'h33, 1'b1);
    a_valid = 1'b0;
    wait_idle(0);
    chk("t3_esc", a_esc_cnt, ea_esc);

    // 4: back-to-back single-byte packets, both SOF modes
    pkt = {8'h11};
    send(0, pkt, 1);
    pkt = {8'h22};
    send(0, pkt, 0);
    wait_idle(0);
    chk("t4a_frame", a_frame_cnt, ea_frm);
    pkt = {8'h11};
    send(1, pkt, 1);
    pkt = {8'h22};
    send(1, pkt, 0);
    wait_idle(1);
    chk("t4b_frame", b_frame_cnt, eb_frm);

    // 5: reset mid-frame
    qa.push_back(8'hC0); qa.push_back(8'h0A); qa.push_back(8'h0B);
    put(0, 8'h0A, 1'b0);
    put(0, 8'h0B, 1'b0);
    a_data = 8'h0C;
    wrst_n = 1'b0;
    ea_frm = '0; ea_esc = '0; eb_frm = '0; eb_esc = '0;
    @(negedge wclk);
    chk("t5_rst_winc",  a_winc, 0);
    chk("t5_rst_busy",  a_busy, 0);
    chk("t5_rst_frame", a_frame_cnt, 0);
    chk("t5_rst_esc",   a_esc_cnt, 0);
    chk("t5_rst_bfrm",  b_frame_cnt, 0);
    a_valid = 1'b0;
    @(negedge wclk);
    wrst_n = 1'b1;
    @(negedge wclk);
    pkt = {8'h7E};
    send(0, pkt, 0);
    wait_idle(0);
    chk("t5_frame", a_frame_cnt, 1);
    chk("t5_esc",   a_esc_cnt, 0);

    // 6: counter wrap on the narrow instance
    for (int k = 0; k < 15; k++) begin
      pkt = {8'(k + 1)};
      send(1, pkt, 0);
    end
    wait_idle(1);
    chk("t6_pre_wrap", b_frame_cnt, 4'hF);
    pkt = {8'hDB};
    send(1, pkt, 0);
    wait_idle(1);
    chk("t6_wrap", b_frame_cnt, 0);
    chk("t6_model", b_frame_cnt, eb_frm);
    chk("t6_esc", b_esc_cnt, eb_esc);

    repeat (3) @(negedge wclk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
